// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master side drives requests and the slave (FIFO) side drives data and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              iPush;
  logic [DATA_W-1:0] iWrData;
  logic              iPop;
  logic              iClrErr;
  logic [DATA_W-1:0] oRdData;
  logic              oFull;
  logic              oEmpty;
  logic              oAlmostFull;
  logic              oAlmostEmpty;
  logic [ADDR_W:0]   oCount;
  logic              oOverflow;
  logic              oUnderflow;

  modport master (
    output iPush, iWrData, iPop, iClrErr,
    input  oRdData, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount, oOverflow, oUnderflow
  );

  modport slave (
    input  iPush, iWrData, iPop, iClrErr,
    output oRdData, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount, oOverflow, oUnderflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock show-ahead FIFO; status reflects an accepted request one cycle after the edge.
// Push refused only when full without a same-cycle pop; refused pushes/pops set sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int AF_LVL = (1 << ADDR_W) - 2,
  parameter int AE_LVL = 2
) (
  input logic              iClk,
  input logic              iRst_n,
  sync_fifo_param_if.slave fifoIf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LVL);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rWrPtr;
  logic [PTR_W-1:0]  rRdPtr;
  logic [PTR_W-1:0]  count;
  logic              rOverflow;
  logic              rUnderflow;
  logic              full;
  logic              empty;
  logic              popOk;
  logic              pushOk;
  logic              pushRej;
  logic              popRej;

  initial begin
    if (AF_LVL < 1 || AF_LVL > DEPTH)
      $error("sync_fifo_param: AF_LVL=%0d outside legal range 1..%0d", AF_LVL, DEPTH);
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1)
      $error("sync_fifo_param: AE_LVL=%0d outside legal range 0..%0d", AE_LVL, DEPTH - 1);
  end

  assign count = rWrPtr - rRdPtr;
  assign empty = (rWrPtr == rRdPtr);
  assign full  = (rWrPtr[ADDR_W-1:0] == rRdPtr[ADDR_W-1:0]) &&
                 (rWrPtr[ADDR_W] != rRdPtr[ADDR_W]);

  // A pop on a full FIFO frees the head slot, so the push may land in it this same edge.
  assign popOk   = fifoIf.iPop && !empty;
  assign pushOk  = fifoIf.iPush && (!full || popOk);
  assign pushRej = fifoIf.iPush && !pushOk;
  assign popRej  = fifoIf.iPop && !popOk;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      rWrPtr     <= '0;
      rRdPtr     <= '0;
      rOverflow  <= 1'b0;
      rUnderflow <= 1'b0;
    end else begin
      if (pushOk)
        rWrPtr <= rWrPtr + PTR_W'(1);
      if (popOk)
        rRdPtr <= rRdPtr + PTR_W'(1);
      // New errors win over a same-cycle clear.
      rOverflow  <= (rOverflow  && !fifoIf.iClrErr) || pushRej;
      rUnderflow <= (rUnderflow && !fifoIf.iClrErr) || popRej;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst_n && pushOk)
      mem[rWrPtr[ADDR_W-1:0]] <= fifoIf.iWrData;
  end

  assign fifoIf.oRdData      = mem[rRdPtr[ADDR_W-1:0]];
  assign fifoIf.oFull        = full;
  assign fifoIf.oEmpty       = empty;
  assign fifoIf.oAlmostFull  = (count >= AF_THR);
  assign fifoIf.oAlmostEmpty = (count <= AE_THR);
  assign fifoIf.oCount       = count;
  assign fifoIf.oOverflow    = rOverflow;
  assign fifoIf.oUnderflow   = rUnderflow;
endmodule
